// File: rtl/crossbar_ctrl.sv
// Crossbar write/form/MAC sequencer.
// Accepts one command at a time, steps the crossbar through reset/set write
// phases, a form pulse or a MAC read window, and returns the MAC result
// through a valid/ready response port. All line drives are registered.
module crossbar_ctrl #(
    parameter int PULSE_CYCLES = 4,
    parameter int FORM_CYCLES  = 16,
    parameter int READ_CYCLES  = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [1:0] cmd_op,
    input  logic [2:0] cmd_row,
    input  logic [7:0] cmd_data,
    output logic       rsp_valid,
    input  logic       rsp_ready,
    output logic [7:0] rsp_data,
    output logic [7:0] bitline,
    output logic [7:0] wordline,
    output logic [7:0] selectline,
    output logic       wenable,
    output logic       form,
    output logic       mac,
    input  logic [7:0] xbar_out,
    output logic       busy
);

    typedef enum logic [2:0] {
        IDLE,
        RST_PH,
        SET_PH,
        FORM_PH,
        READ_PH,
        RESP
    } state_t;

    localparam logic [1:0] OP_WRITE = 2'b00;
    localparam logic [1:0] OP_MAC   = 2'b01;
    localparam logic [1:0] OP_FORM  = 2'b10;

    // Counter reload values: a phase of N cycles counts N-1 down to 0.
    localparam logic [7:0] PULSE_LOAD = 8'(PULSE_CYCLES - 1);
    localparam logic [7:0] FORM_LOAD  = 8'(FORM_CYCLES - 1);
    localparam logic [7:0] READ_LOAD  = 8'(READ_CYCLES - 1);

    state_t     state;
    state_t     state_next;
    logic [7:0] cnt;
    logic [7:0] cnt_next;
    logic [2:0] row_reg;
    logic [7:0] data_reg;
    logic       accept;

    logic [7:0] bitline_d;
    logic [7:0] wordline_d;
    logic [7:0] selectline_d;
    logic       wenable_d;
    logic       form_d;
    logic       mac_d;

    // The opcode only steers the IDLE exit; once accepted, its effect lives
    // entirely in the state register, so only row and data are kept.
    assign accept    = cmd_valid && (state == IDLE);
    assign cmd_ready = (state == IDLE);
    assign busy      = (state != IDLE);
    assign rsp_valid = (state == RESP);

    // State and phase counter register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= 8'd0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    // Latch the command operands so later cmd_* changes are ignored.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            row_reg  <= 3'd0;
            data_reg <= 8'd0;
        end else if (accept) begin
            row_reg  <= cmd_row;
            data_reg <= cmd_data;
        end
    end

    // Next-state and counter sequencing.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        case (state)
            IDLE: begin
                if (accept) begin
                    case (cmd_op)
                        OP_WRITE: begin
                            state_next = RST_PH;
                            cnt_next   = PULSE_LOAD;
                        end
                        OP_MAC: begin
                            state_next = READ_PH;
                            cnt_next   = READ_LOAD;
                        end
                        OP_FORM: begin
                            state_next = FORM_PH;
                            cnt_next   = FORM_LOAD;
                        end
                        default: begin
                            state_next = IDLE;
                        end
                    endcase
                end
            end
            RST_PH: begin
                if (cnt == 8'd0) begin
                    state_next = SET_PH;
                    cnt_next   = PULSE_LOAD;
                end else begin
                    cnt_next = cnt - 8'd1;
                end
            end
            SET_PH, FORM_PH: begin
                if (cnt == 8'd0) begin
                    state_next = IDLE;
                end else begin
                    cnt_next = cnt - 8'd1;
                end
            end
            READ_PH: begin
                if (cnt == 8'd0) begin
                    state_next = RESP;
                end else begin
                    cnt_next = cnt - 8'd1;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
                cnt_next   = 8'd0;
            end
        endcase
    end

    // Line decode for the current state; bitline and selectline are never
    // both driven in the same phase, so they cannot collide on any bit.
    always_comb begin
        bitline_d    = 8'd0;
        wordline_d   = 8'd0;
        selectline_d = 8'd0;
        wenable_d    = 1'b0;
        form_d       = 1'b0;
        mac_d        = 1'b0;
        case (state)
            RST_PH: begin
                wordline_d   = 8'b1 << row_reg;
                selectline_d = ~data_reg;
                wenable_d    = 1'b1;
            end
            SET_PH: begin
                wordline_d = 8'b1 << row_reg;
                bitline_d  = data_reg;
                wenable_d  = 1'b1;
            end
            FORM_PH: begin
                wordline_d = 8'b1 << row_reg;
                bitline_d  = data_reg;
                wenable_d  = 1'b1;
                form_d     = 1'b1;
            end
            READ_PH: begin
                wordline_d = data_reg;
                mac_d      = 1'b1;
            end
            default: begin
                wenable_d = 1'b0;
            end
        endcase
    end

    // Registered line drivers, one cycle behind the state.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            bitline    <= 8'd0;
            wordline   <= 8'd0;
            selectline <= 8'd0;
            wenable    <= 1'b0;
            form       <= 1'b0;
            mac        <= 1'b0;
        end else begin
            bitline    <= bitline_d;
            wordline   <= wordline_d;
            selectline <= selectline_d;
            wenable    <= wenable_d;
            form       <= form_d;
            mac        <= mac_d;
        end
    end

    // Capture the crossbar output on the final read cycle and hold it.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rsp_data <= 8'd0;
        end else if ((state == READ_PH) && (cnt == 8'd0)) begin
            rsp_data <= xbar_out;
        end
    end

endmodule

// File: tb/tb_crossbar_ctrl.sv
// Self-checking bench for crossbar_ctrl with default parameters.
module tb_crossbar_ctrl;

    localparam int READ_CYCLES = 2;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [1:0] cmd_op;
    logic [2:0] cmd_row;
    logic [7:0] cmd_data;
    logic       rsp_valid;
    logic       rsp_ready;
    logic [7:0] rsp_data;
    logic [7:0] bitline;
    logic [7:0] wordline;
    logic [7:0] selectline;
    logic       wenable;
    logic       form;
    logic       mac;
    logic [7:0] xbar_out;
    logic       busy;

    int total = 0;
    int bad   = 0;
    logic [7:0] rsp_q[$];

    typedef struct {
        logic [1:0] op;
        logic [2:0] row;
        logic [7:0] data;
        logic [7:0] xbar;
        int         rdelay;
        logic [7:0] wl;
        logic [7:0] rst_sl;
        logic [7:0] set_bl;
        int         n_rst;
        int         n_set;
        int         n_form;
        int         n_mac;
        int         n_busy;
        int         n_rsp;
        logic [7:0] rsp;
    } vec_t;

    vec_t vecs[8];

    always #5 clk = ~clk;

    crossbar_ctrl dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_op     (cmd_op),
        .cmd_row    (cmd_row),
        .cmd_data   (cmd_data),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_data   (rsp_data),
        .bitline    (bitline),
        .wordline   (wordline),
        .selectline (selectline),
        .wenable    (wenable),
        .form       (form),
        .mac        (mac),
        .xbar_out   (xbar_out),
        .busy       (busy)
    );

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    function automatic logic linesIdle();
        return (bitline == 8'd0) && (wordline == 8'd0) && (selectline == 8'd0)
            && !wenable && !form && !mac;
    endfunction

    // Offer a command once the controller is ready; returns at the first
    // falling edge after acceptance with the command bus scrambled.
    task automatic applyStimulus(input logic [1:0] op, input logic [2:0] row, input logic [7:0] data);
        int waitc = 0;
        while (!cmd_ready && waitc < 100) begin
            @(negedge clk);
            waitc++;
        end
        if (!cmd_ready) checkOutput("ready_timeout", 32'd0, 32'd1);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_row   = row;
        cmd_data  = data;
        @(negedge clk);
        cmd_valid = 1'b0;
        cmd_op    = 2'b11;
        cmd_row   = row + 3'd1;
        cmd_data  = ~data;
    endtask

    // Run one table vector to completion and compare its observed trace.
    task automatic runVector(input int idx);
        vec_t v;
        int n_rst = 0, n_set = 0, n_form = 0, n_mac = 0, n_busy = 0;
        int vs = 0, conflicts = 0, unstable = 0, ready_bad = 0;
        logic [7:0] first_rsp = 8'd0;
        logic [7:0] exp_rsp;
        logic done = 1'b0;
        v = vecs[idx];
        if (v.op == 2'b01) rsp_q.push_back(v.rsp);
        applyStimulus(v.op, v.row, v.data);
        for (int k = 0; k < 200 && !done; k++) begin
            if (k > 0) @(negedge clk);
            xbar_out = (k == READ_CYCLES - 1) ? v.xbar : ~v.xbar;
            if ((bitline & selectline) != 8'd0) conflicts++;
            if (busy) n_busy++;
            if (wenable && !form && !mac && wordline == v.wl && bitline == 8'd0 && selectline == v.rst_sl) n_rst++;
            if (wenable && !form && !mac && wordline == v.wl && bitline == v.set_bl && selectline == 8'd0) n_set++;
            if (wenable && form && !mac && wordline == v.wl && bitline == v.set_bl && selectline == 8'd0) n_form++;
            if (mac && !wenable && !form && wordline == v.wl && bitline == 8'd0 && selectline == 8'd0) n_mac++;
            if (rsp_valid) begin
                vs++;
                if (cmd_ready) ready_bad++;
                if (vs == 1) begin
                    first_rsp = rsp_data;
                    if (rsp_q.size() == 0) begin
                        checkOutput($sformatf("v%0d_unexpected_rsp", idx), 32'd1, 32'd0);
                    end else begin
                        exp_rsp = rsp_q.pop_front();
                        checkOutput($sformatf("v%0d_rsp_data", idx), rsp_data, exp_rsp);
                    end
                end else if (rsp_data != first_rsp) begin
                    unstable++;
                end
                rsp_ready = (vs > v.rdelay);
            end else begin
                rsp_ready = 1'b0;
            end
            done = !busy && linesIdle();
        end
        rsp_ready = 1'b0;
        checkOutput($sformatf("v%0d_done", idx), done, 1'b1);
        checkOutput($sformatf("v%0d_rst_cycles", idx), n_rst, v.n_rst);
        checkOutput($sformatf("v%0d_set_cycles", idx), n_set, v.n_set);
        checkOutput($sformatf("v%0d_form_cycles", idx), n_form, v.n_form);
        checkOutput($sformatf("v%0d_mac_cycles", idx), n_mac, v.n_mac);
        checkOutput($sformatf("v%0d_busy_cycles", idx), n_busy, v.n_busy);
        checkOutput($sformatf("v%0d_rsp_count", idx), (vs > 0) ? 1 : 0, v.n_rsp);
        checkOutput($sformatf("v%0d_bl_sl_conflict", idx), conflicts, 0);
        checkOutput($sformatf("v%0d_rsp_unstable", idx), unstable, 0);
        checkOutput($sformatf("v%0d_cmd_ready_in_resp", idx), ready_bad, 0);
        checkOutput($sformatf("v%0d_cmd_ready_after", idx), cmd_ready, 1'b1);
    endtask

    initial begin
        int first_ready;
        int got;
        int conflicts;
        int act;
        logic done;

        //          op     row   data   xbar   dly  wl     rst_sl set_bl rst set form mac busy rsp rspval
        vecs[0] = '{2'b00, 3'd2, 8'hA5, 8'h00, 0, 8'h04, 8'h5A, 8'hA5, 4, 4, 0,  0, 8,  0, 8'h00};
        vecs[1] = '{2'b10, 3'd7, 8'hFF, 8'h00, 0, 8'h80, 8'h00, 8'hFF, 0, 0, 16, 0, 16, 0, 8'h00};
        vecs[2] = '{2'b01, 3'd0, 8'h0F, 8'h3C, 5, 8'h0F, 8'h00, 8'h00, 0, 0, 0,  2, 8,  1, 8'h3C};
        vecs[3] = '{2'b00, 3'd0, 8'h00, 8'h00, 0, 8'h01, 8'hFF, 8'h00, 4, 4, 0,  0, 8,  0, 8'h00};
        vecs[4] = '{2'b00, 3'd5, 8'h3C, 8'h00, 0, 8'h20, 8'hC3, 8'h3C, 4, 4, 0,  0, 8,  0, 8'h00};
        vecs[5] = '{2'b11, 3'd3, 8'h77, 8'h00, 0, 8'h00, 8'h00, 8'h00, 0, 0, 0,  0, 0,  0, 8'h00};
        vecs[6] = '{2'b01, 3'd4, 8'h81, 8'hC7, 0, 8'h81, 8'h00, 8'h00, 0, 0, 0,  2, 3,  1, 8'hC7};
        vecs[7] = '{2'b10, 3'd1, 8'h5A, 8'h00, 0, 8'h02, 8'h00, 8'h5A, 0, 0, 16, 0, 16, 0, 8'h00};

        rst_n     = 1'b0;
        cmd_valid = 1'b0;
        cmd_op    = 2'b00;
        cmd_row   = 3'd0;
        cmd_data  = 8'd0;
        rsp_ready = 1'b0;
        xbar_out  = 8'h00;
        repeat (3) @(negedge clk);

        // Reset state.
        checkOutput("reset_cmd_ready", cmd_ready, 1'b1);
        checkOutput("reset_rsp_valid", rsp_valid, 1'b0);
        checkOutput("reset_rsp_data", rsp_data, 8'h00);
        checkOutput("reset_busy", busy, 1'b0);
        checkOutput("reset_lines_idle", linesIdle(), 1'b1);
        rst_n = 1'b1;
        @(negedge clk);

        // Table-driven vectors.
        for (int i = 0; i < 8; i++) begin
            runVector(i);
            @(negedge clk);
        end

        // Reset in the second SET_PH cycle aborts the write.
        applyStimulus(2'b00, 3'd2, 8'hA5);
        repeat (5) @(negedge clk);
        checkOutput("abort_in_set_bitline", bitline, 8'hA5);
        rst_n = 1'b0;
        @(negedge clk);
        checkOutput("abort_lines_idle", linesIdle(), 1'b1);
        checkOutput("abort_cmd_ready", cmd_ready, 1'b1);
        checkOutput("abort_rsp_valid", rsp_valid, 1'b0);
        rst_n = 1'b1;
        act = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (!linesIdle() || busy) act++;
        end
        checkOutput("abort_no_activity", act, 0);

        // Reset during a MAC read produces no response.
        xbar_out = 8'h55;
        applyStimulus(2'b01, 3'd0, 8'hF0);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        act = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (rsp_valid || busy || !linesIdle()) act++;
        end
        checkOutput("mac_abort_no_rsp", act, 0);
        checkOutput("mac_abort_rsp_data", rsp_data, 8'h00);

        // Back-to-back WRITE then MAC with cmd_valid held high.
        xbar_out = 8'h99;
        rsp_q.push_back(8'h99);
        cmd_valid = 1'b1;
        cmd_op    = 2'b00;
        cmd_row   = 3'd3;
        cmd_data  = 8'h96;
        @(negedge clk);
        cmd_op    = 2'b01;
        cmd_row   = 3'd0;
        cmd_data  = 8'h0F;
        first_ready = -1;
        got = 0;
        conflicts = 0;
        done = 1'b0;
        for (int k = 0; k < 100 && !done; k++) begin
            if (k > 0) @(negedge clk);
            if ((bitline & selectline) != 8'd0) conflicts++;
            if (first_ready >= 0 && k == first_ready + 1) begin
                cmd_valid = 1'b0;
                checkOutput("b2b_second_accepted", busy, 1'b1);
            end
            if (first_ready >= 0 && k == first_ready + 2) begin
                checkOutput("b2b_mac_wordline", wordline, 8'h0F);
                checkOutput("b2b_mac_strobe", mac, 1'b1);
            end
            if (cmd_ready && first_ready < 0) first_ready = k;
            if (rsp_valid) begin
                got++;
                if (rsp_q.size() == 0) begin
                    checkOutput("b2b_unexpected_rsp", 32'd1, 32'd0);
                end else begin
                    checkOutput("b2b_rsp_data", rsp_data, rsp_q.pop_front());
                end
                rsp_ready = 1'b1;
            end else begin
                rsp_ready = 1'b0;
            end
            done = (got > 0) && !busy && !rsp_valid;
        end
        cmd_valid = 1'b0;
        rsp_ready = 1'b0;
        checkOutput("b2b_done", done, 1'b1);
        checkOutput("b2b_first_idle_cycle", first_ready, 8);
        checkOutput("b2b_rsp_count", got, 1);
        checkOutput("b2b_bl_sl_conflict", conflicts, 0);
        checkOutput("scoreboard_empty", rsp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/crossbar_ctrl.md
CROSSBAR_CTRL -- requirements
Module: crossbar_ctrl

Interface
REQ-001 Parameter PULSE_CYCLES, default 4, SHALL set the cycle count of each write phase (reset and set); legal range 1..255.
REQ-002 Parameter FORM_CYCLES, default 16, SHALL set the cycle count of the form pulse; legal range 1..255.
REQ-003 Parameter READ_CYCLES, default 2, SHALL set the cycle count of the MAC read window; legal range 2..255.
REQ-004 clk  in  1  sole clock; all state updates on its rising edge.
REQ-005 rst_n  in  1  reset, synchronous, active-low.
REQ-006 cmd_valid  in  1  command offered.
REQ-007 cmd_ready  out  1  controller can accept a command.
REQ-008 cmd_op  in  2  00 WRITE, 01 MAC, 10 FORM, 11 reserved.
REQ-009 cmd_row  in  3  target row for WRITE/FORM.
REQ-010 cmd_data  in  8  row data for WRITE/FORM; wordline input vector for MAC.
REQ-011 rsp_valid  out  1  MAC result available.
REQ-012 rsp_ready  in  1  consumer accepts the result.
REQ-013 rsp_data  out  8  captured MAC result.
REQ-014 bitline, wordline, selectline  out  8 each  crossbar drive lines.
REQ-015 wenable, form, mac  out  1 each  crossbar mode strobes.
REQ-016 xbar_out  in  8  crossbar output vector.
REQ-017 busy  out  1  high in every state except IDLE.

Function
REQ-018 FSM states SHALL be IDLE, RST_PH, SET_PH, FORM_PH, READ_PH, RESP, with one 8-bit phase counter.
REQ-019 cmd_ready SHALL be 1 only in IDLE; a command is accepted on any cycle with cmd_valid & cmd_ready.
REQ-020 On acceptance, cmd_op, cmd_row and cmd_data SHALL be latched; later changes to cmd_* have no effect until the next acceptance.
REQ-021 Accepted WRITE: IDLE->RST_PH for PULSE_CYCLES cycles, then SET_PH for PULSE_CYCLES cycles, then IDLE.
REQ-022 Accepted FORM: IDLE->FORM_PH for FORM_CYCLES cycles, then IDLE.
REQ-023 Accepted MAC: IDLE->READ_PH for READ_CYCLES cycles, then RESP.
REQ-024 Accepted op 11: consumed, FSM stays in IDLE, no line activity.
REQ-025 IDLE and RESP drive: bitline=0, wordline=0, selectline=0, all strobes 0.
REQ-026 RST_PH drive: wordline=onehot(row), bitline=0, selectline=~data, wenable=1.
REQ-027 SET_PH drive: wordline=onehot(row), bitline=data, selectline=0, wenable=1.
REQ-028 FORM_PH drive: same lines as SET_PH, plus wenable=1 and form=1.
REQ-029 READ_PH drive: wordline=data, bitline=0, selectline=0, mac=1.
REQ-030 bitline and selectline SHALL never both be 1 on the same bit in any cycle.
REQ-031 In the last READ_PH cycle, xbar_out SHALL be registered into rsp_data.
REQ-032 In RESP, rsp_valid=1 and rsp_data holds stable until rsp_ready=1; that cycle transitions RESP->IDLE.
REQ-033 The phase counter SHALL load N-1 on phase entry, decrement each cycle, and change phase on the cycle it reads 0, so each phase lasts exactly N cycles.
REQ-034 All drive outputs SHALL be registered; line changes take effect the cycle after the state change.

Reset
REQ-035 With rst_n=0 at a clock edge, the FSM SHALL go to IDLE and the counter to 0.
REQ-036 Reset outputs: cmd_ready=1, rsp_valid=0, rsp_data=0, busy=0, all lines and strobes 0.
REQ-037 Reset mid-operation SHALL abort the operation with no further line activity; no response is produced for an aborted MAC.

Verification
REQ-038 WRITE row 2, data 0xA5, defaults -> 4 cycles wl=0x04, sl=0x5A, bl=0; then 4 cycles bl=0xA5, sl=0; then IDLE; busy high for 8 cycles.
REQ-039 FORM row 7, data 0xFF -> 16 cycles form=1, wl=0x80, bl=0xFF, sl=0; then IDLE.
REQ-040 MAC data 0x0F, xbar_out=0x3C on last read cycle, rsp_ready held 0 for 5 cycles -> rsp_valid=1 and rsp_data=0x3C stable throughout; cmd_ready=0 until the cycle after the handshake.
REQ-041 rst_n pulsed low in the 2nd SET_PH cycle -> next cycle all lines 0, cmd_ready=1, rsp_valid=0.
REQ-042 Back-to-back WRITE then MAC with cmd_valid held high -> second command accepted on the first IDLE cycle; the REQ-030 check passes on every cycle.
